// File: rtl/riscv_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_if
// Brief    : Instruction fetch stage. Issues in-order word fetches over a
//            valid/ready request channel, tags returned words with their PC in
//            a small FIFO and presents them to decode. Redirect flushes both
//            buffered and in-flight fetches.
// Options  : RISCV_IF_MISALIGN_EXC_EN - a misaligned redirect target produces
//            one exception entry and halts fetch until the next redirect.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_if #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic            exception
);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_SW = c_CW + 1;

`ifdef RISCV_IF_MISALIGN_EXC_EN
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_drop;
    logic [c_CW-1:0] r_count;
    logic [XLEN-1:0] r_iq_pc [DEPTH];
    logic [c_PW-1:0] r_iq_wptr;
    logic [c_PW-1:0] r_iq_rptr;
    logic [XLEN-1:0] r_fifo_ins [DEPTH];
    logic [XLEN-1:0] r_fifo_pc [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic            r_exc_pend;

    logic [XLEN-1:0] w_redirect_pc;
    logic            w_misalign;
    logic            w_rsp;
    logic            w_rsp_keep;
    logic            w_pop;
    logic            w_pop_fifo;
    logic            w_accept;
    logic [c_SW-1:0] w_used;

`ifdef RISCV_IF_MISALIGN_EXC_EN
    assign w_redirect_pc = redirect_pc;
    assign w_misalign    = (redirect_pc[1:0] != 2'b00);
    assign exception     = r_exc_pend && !redirect;
`else
    logic w_unused_lsb;
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_misalign    = 1'b0;
    assign exception     = 1'b0;
    assign w_unused_lsb  = ^redirect_pc[1:0];
`endif

    // Responses with nothing outstanding are ignored; a redirect discards any
    // word arriving in its own cycle.
    assign w_rsp      = mem_rsp_valid && (r_inflight != '0);
    assign w_rsp_keep = w_rsp && !redirect && (r_drop == '0);

    assign out_valid  = ((r_count != '0) || r_exc_pend) && !redirect;
    assign w_pop      = out_valid && out_ready;
    assign w_pop_fifo = w_pop && (r_count != '0);

    // Credit: every outstanding fetch owns a FIFO slot. A slot freed by this
    // cycle's pop is reusable immediately, which keeps one fetch per cycle with
    // DEPTH = 2. Once true the condition stays true until the request is taken,
    // since only an accept can raise the occupancy.
    assign w_used        = c_SW'(r_inflight) + c_SW'(r_count) - c_SW'(w_pop_fifo);
    assign mem_req_valid = (r_state == ST_RUN) && !redirect && (w_used < c_SW'(DEPTH));
    assign mem_addr      = r_fetch_pc;
    assign w_accept      = mem_req_valid && mem_req_ready;

    assign instruction = (r_count != '0) ? r_fifo_ins[r_rptr] : '0;
    assign pc          = (r_count != '0) ? r_fifo_pc[r_rptr]
                       : (r_exc_pend ? r_fetch_pc : '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave RESET after one cycle; redirect picks RUN or HALT
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RESET) begin
            w_state_nxt = ST_RUN;
        end
`ifdef RISCV_IF_MISALIGN_EXC_EN
        if (redirect) begin
            w_state_nxt = w_misalign ? ST_HALT : ST_RUN;
        end
`endif
    end

    // Fetch PC, in-flight PC queue, drop counter and output FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_iq_wptr  <= '0;
            r_iq_rptr  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_exc_pend <= 1'b0;
        end else begin
            r_inflight <= r_inflight + c_CW'(w_accept) - c_CW'(w_rsp);
            if (w_accept) begin
                r_iq_pc[r_iq_wptr] <= r_fetch_pc;
                r_iq_wptr          <= r_iq_wptr + c_PW'(1);
                r_fetch_pc         <= r_fetch_pc + XLEN'(4);
            end
            if (w_rsp) begin
                r_iq_rptr <= r_iq_rptr + c_PW'(1);
            end
            if (redirect) begin
                // Everything still outstanding after this cycle is stale
                r_fetch_pc <= w_redirect_pc;
                r_drop     <= r_inflight - c_CW'(w_rsp);
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_exc_pend <= w_misalign;
            end else begin
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CW'(1);
                end
                if (w_rsp_keep) begin
                    r_fifo_ins[r_wptr] <= mem_rsp_data;
                    r_fifo_pc[r_wptr]  <= r_iq_pc[r_iq_rptr];
                    r_wptr             <= r_wptr + c_PW'(1);
                end
                if (w_pop_fifo) begin
                    r_rptr <= r_rptr + c_PW'(1);
                end
                r_count <= r_count + c_CW'(w_rsp_keep) - c_CW'(w_pop_fifo);
                if (w_pop && (r_count == '0)) begin
                    r_exc_pend <= 1'b0;
                end
            end
        end
    end

    // Memory must never answer without an outstanding request
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rsp_valid && (r_inflight == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_if
// Brief    : Self-checking bench for riscv_if with a variable-latency in-order
//            memory model and an expected-output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_if;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        exception;

    riscv_if #(.XLEN(32), .RESET_PC(32'h100), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .instruction(instruction), .pc(pc),
        .exception(exception)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct { logic [31:0] pc; logic [31:0] ins; logic exc; } exp_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;
    exp_t exp_q[$];
    rsp_t mq[$];
    int   cyc   = 0;
    int   lat   = 1;
    int   n_acc = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back('{pc: a, ins: memf(a), exc: 1'b0});
        end
    endtask

    task automatic wait_out(input string tag, input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        assert (out_valid === 1'b1) else begin
            tests_failed++;
            $error("FAIL %s: out_valid %b after %0d cycles, expected 1", tag, out_valid, budget);
        end
    endtask

    // In-order memory: fixed latency per request, one response per cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= '0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                mq.push_back('{due: cyc + lat, data: memf(mem_addr)});
                n_acc <= n_acc + 1;
            end
            if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
                mem_rsp_valid <= 1'b1;
                mem_rsp_data  <= mq[0].data;
                void'(mq.pop_front());
            end else begin
                mem_rsp_valid <= 1'b0;
            end
        end
    end

    // Scoreboard: every decode handshake must match the next expected entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            tests_run++;
            assert (exp_q.size() != 0) else begin
                tests_failed++;
                $error("FAIL out_unexpected: observed pc %h, expected no output", pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pc", pc, e.pc);
                check("out_ins", instruction, e.ins);
                check("out_exc", 32'(exception), 32'(e.exc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst = 1'b1; out_ready = 1'b1; mem_req_ready = 1'b1;
        redirect = 1'b0; redirect_pc = '0; lat = 1;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_exception", 32'(exception), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_pc", pc, 32'd0);

        // Streaming fetch from RESET_PC
        exp_q.delete();
        push_stream(32'h100, 64);
        rst = 1'b0;
        tick();
        check("b_req_valid0", 32'(mem_req_valid), 32'd1);
        check("b_addr0", mem_addr, 32'h100);
        check("b_out_valid0", 32'(out_valid), 32'd0);
        tick();
        check("b_addr1", mem_addr, 32'h104);
        check("b_out_valid1", 32'(out_valid), 32'd0);
        tick();
        check("b_addr2", mem_addr, 32'h108);
        check("b_out_valid2", 32'(out_valid), 32'd1);
        check("b_pc2", pc, 32'h100);
        repeat (5) tick();

        // Decode stall: credits cap outstanding work at DEPTH
        out_ready = 1'b0;
        a0 = n_acc;
        repeat (10) tick();
        tests_run++;
        assert (n_acc - a0 <= DEPTH) else begin
            tests_failed++;
            $error("FAIL stall_accepts: observed %0d accepts, expected at most %0d", n_acc - a0, DEPTH);
        end
        check("stall_req_valid", 32'(mem_req_valid), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head_pc", pc, exp_q[0].pc);
        out_ready = 1'b1;
        repeat (8) tick();

        // Mid-operation reset, then memory back-pressure on the second fetch
        rst = 1'b1;
        tick(); tick();
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_req_valid", 32'(mem_req_valid), 32'd0);
        exp_q.delete();
        push_stream(32'h100, 64);
        rst = 1'b0;
        tick();
        check("bp_addr0", mem_addr, 32'h100);
        tick();
        mem_req_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", 32'(mem_req_valid), 32'd1);
            check("bp_hold_addr", mem_addr, 32'h104);
            if (i < 3) tick();
        end
        mem_req_ready = 1'b1;
        tick();
        check("bp_addr_next", mem_addr, 32'h108);
        check("bp_single_accept", 32'(n_acc - a0), 32'd1);
        repeat (6) tick();

        // Redirect in a cycle carrying a response and a ready decode
        check("f_pre_out_valid", 32'(out_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h3000;
        exp_q.delete();
        push_stream(32'h3000, 64);
        #1;
        check("f_redir_out_valid", 32'(out_valid), 32'd0);
        check("f_redir_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("f_post_out_valid", 32'(out_valid), 32'd0);
        check("f_post_req_valid", 32'(mem_req_valid), 32'd1);
        check("f_post_addr", mem_addr, 32'h3000);
        wait_out("f_wait_out", 10);
        check("f_first_pc", pc, 32'h3000);
        repeat (4) tick();

        // Redirect with two fetches outstanding in a slow memory
        rst = 1'b1;
        tick(); tick();
        lat = 4;
        exp_q.delete();
        rst = 1'b0;
        tick(); tick(); tick();
        check("e_full_req_valid", 32'(mem_req_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h2000;
        push_stream(32'h2000, 64);
        tick();
        redirect = 1'b0;
        #1;
        check("e_post_req_valid", 32'(mem_req_valid), 32'd0);
        wait_out("e_wait_out", 20);
        check("e_first_pc", pc, 32'h2000);
        check("e_first_ins", instruction, memf(32'h2000));
        lat = 1;
        repeat (10) tick();

`ifdef RISCV_IF_MISALIGN_EXC_EN
        // Misaligned redirect: one exception entry, fetch halted
        redirect = 1'b1; redirect_pc = 32'h2002;
        exp_q.delete();
        exp_q.push_back('{pc: 32'h2002, ins: 32'h0, exc: 1'b1});
        #1;
        check("g_redir_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("g_exc_out_valid", 32'(out_valid), 32'd1);
        check("g_exc_pc", pc, 32'h2002);
        check("g_exc_ins", instruction, 32'h0);
        check("g_exc_flag", 32'(exception), 32'd1);
        check("g_halt_req0", 32'(mem_req_valid), 32'd0);
        tick();
        check("g_exc_once", 32'(out_valid), 32'd0);
        repeat (5) tick();
        check("g_halt_req1", 32'(mem_req_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h3000;
        push_stream(32'h3000, 64);
        tick();
        redirect = 1'b0;
        #1;
        check("g_resume_addr", mem_addr, 32'h3000);
        wait_out("g_wait_out", 10);
        check("g_resume_pc", pc, 32'h3000);
        repeat (4) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
